// File: rtl/reflet_float_mult_seq.sv
// Sequential floating-point multiplier for the Reflet FPU: shift-add mantissa product,
// normalisation and round-to-nearest-even, with valid/ready handshakes on both sides.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | in_ready high, waiting for operands
// ST_MULT  | one multiplier bit per cycle into the accumulator
// ST_ROUND | normalise, round and pack (special results pass straight through)
// ST_DONE  | out_valid high, result and flags held until out_ready
module reflet_float_mult_seq #(
    parameter int float_size = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [float_size-1:0] in1,
    input  logic [float_size-1:0] in2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [float_size-1:0] mult,
    output logic                  flag_invalid,
    output logic                  flag_overflow,
    output logic                  flag_underflow
);
    localparam int E  = (float_size == 16) ? 5 : ((float_size == 64) ? 11 : 8);
    localparam int M  = float_size - 1 - E;
    localparam int CW = $clog2(M + 1);
    localparam int AW = 2 * M + 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MULT  = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [E-1:0]        EXP_ONES = '1;
    localparam logic signed [E+1:0] BIAS     = (E+2)'((1 << (E - 1)) - 1);
    localparam logic signed [E+1:0] EXP_MAX  = (E+2)'((1 << E) - 1);
    localparam logic signed [E+1:0] EXP_ONE  = (E+2)'(1);
    localparam logic signed [E+1:0] EXP_ZERO = '0;

    logic [1:0]    state;
    logic [CW-1:0] counter;
    logic [AW-1:0] acc;
    logic [M:0]    mcand;
    logic [M:0]    mplier;
    logic          sign_r;
    logic          special_r;
    logic [E-1:0]  exp1_r;
    logic [E-1:0]  exp2_r;

    logic [E-1:0] exp_a;
    logic [E-1:0] exp_b;
    logic [M-1:0] mnt_a;
    logic [M-1:0] mnt_b;
    logic         sign_in;
    logic         nan_a;
    logic         nan_b;
    logic         inf_a;
    logic         inf_b;
    logic         zero_a;
    logic         zero_b;
    logic         special_in;

    assign exp_a   = in1[float_size-2 -: E];
    assign exp_b   = in2[float_size-2 -: E];
    assign mnt_a   = in1[M-1:0];
    assign mnt_b   = in2[M-1:0];
    assign sign_in = in1[float_size-1] ^ in2[float_size-1];

    // Subnormals have exponent 0 and are treated as zero.
    assign nan_a  = (exp_a == EXP_ONES) && (mnt_a != '0);
    assign nan_b  = (exp_b == EXP_ONES) && (mnt_b != '0);
    assign inf_a  = (exp_a == EXP_ONES) && (mnt_a == '0);
    assign inf_b  = (exp_b == EXP_ONES) && (mnt_b == '0);
    assign zero_a = (exp_a == '0);
    assign zero_b = (exp_b == '0);

    assign special_in = nan_a | nan_b | inf_a | inf_b | zero_a | zero_b;

    logic [float_size-1:0] spec_res;
    logic                  spec_inv;

    always_comb begin
        spec_res = '0;
        spec_inv = 1'b0;
        if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
            spec_res = {1'b0, EXP_ONES, 1'b1, {(M-1){1'b0}}};
            spec_inv = 1'b1;
        end else if (inf_a || inf_b) begin
            spec_res = {sign_in, EXP_ONES, {M{1'b0}}};
        end else begin
            spec_res = {sign_in, {(float_size-1){1'b0}}};
        end
    end

    logic [AW-1:0] addend;

    always_comb begin
        addend = '0;
        if (mplier[counter]) begin
            addend = {{(M+1){1'b0}}, mcand} << counter;
        end
    end

    logic signed [E+1:0]   exp_sum;
    logic signed [E+1:0]   exp_norm;
    logic signed [E+1:0]   exp_fin;
    logic [M-1:0]          frac_raw;
    logic [M:0]            frac_inc;
    logic                  guard;
    logic                  sticky;
    logic                  round_up;
    logic                  res_ovf;
    logic                  res_unf;
    logic [float_size-1:0] round_res;

    always_comb begin
        exp_sum = $signed({2'b00, exp1_r}) + $signed({2'b00, exp2_r}) - BIAS;
        if (acc[AW-1]) begin
            frac_raw = acc[2*M:M+1];
            guard    = acc[M];
            sticky   = |acc[M-1:0];
            exp_norm = exp_sum + EXP_ONE;
        end else begin
            frac_raw = acc[2*M-1:M];
            guard    = acc[M-1];
            sticky   = |acc[M-2:0];
            exp_norm = exp_sum;
        end
        round_up = guard & (sticky | frac_raw[0]);
        frac_inc = {1'b0, frac_raw} + {{M{1'b0}}, round_up};
        // A carry out of the fraction leaves it all-zero and bumps the exponent.
        exp_fin  = frac_inc[M] ? (exp_norm + EXP_ONE) : exp_norm;
        res_ovf  = 1'b0;
        res_unf  = 1'b0;
        if (exp_fin >= EXP_MAX) begin
            round_res = {sign_r, EXP_ONES, {M{1'b0}}};
            res_ovf   = 1'b1;
        end else if (exp_fin <= EXP_ZERO) begin
            round_res = {sign_r, {(float_size-1){1'b0}}};
            res_unf   = 1'b1;
        end else begin
            round_res = {sign_r, exp_fin[E-1:0], frac_inc[M-1:0]};
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            counter        <= '0;
            acc            <= '0;
            mcand          <= '0;
            mplier         <= '0;
            sign_r         <= 1'b0;
            special_r      <= 1'b0;
            exp1_r         <= '0;
            exp2_r         <= '0;
            mult           <= '0;
            flag_invalid   <= 1'b0;
            flag_overflow  <= 1'b0;
            flag_underflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        sign_r <= sign_in;
                        exp1_r <= exp_a;
                        exp2_r <= exp_b;
                        if (special_in) begin
                            // Specials still pass through ROUND so their latency is fixed.
                            special_r    <= 1'b1;
                            mult         <= spec_res;
                            flag_invalid <= spec_inv;
                            state        <= ST_ROUND;
                        end else begin
                            special_r <= 1'b0;
                            counter   <= '0;
                            acc       <= '0;
                            mcand     <= {1'b1, mnt_a};
                            mplier    <= {1'b1, mnt_b};
                            state     <= ST_MULT;
                        end
                    end
                end
                ST_MULT: begin
                    acc     <= acc + addend;
                    counter <= counter + 1'b1;
                    if (counter == CW'(M)) begin
                        state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    if (!special_r) begin
                        mult           <= round_res;
                        flag_overflow  <= res_ovf;
                        flag_underflow <= res_unf;
                    end
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        flag_invalid   <= 1'b0;
                        flag_overflow  <= 1'b0;
                        flag_underflow <= 1'b0;
                        state          <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reflet_float_mult_seq.sv
// Bench for reflet_float_mult_seq: directed vectors on 32- and 16-bit instances,
// checked against an arithmetic reference model and hand-computed literals.
module tb_reflet_float_mult_seq;
    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] in1   = '0;
    logic [31:0] in2   = '0;
    logic        iv32  = 1'b0;
    logic        iv16  = 1'b0;
    logic        or32  = 1'b1;
    logic        or16  = 1'b1;

    logic        ir32, ov32, fi32, fo32, fu32;
    logic [31:0] m32;
    logic        ir16, ov16, fi16, fo16, fu16;
    logic [15:0] m16;

    logic [31:0] exp32  = '0;
    logic [2:0]  expf32 = '0;
    logic [15:0] exp16  = '0;
    logic [2:0]  expf16 = '0;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    reflet_float_mult_seq #(.float_size(32)) dut32 (
        .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32),
        .in1(in1), .in2(in2), .out_valid(ov32), .out_ready(or32), .mult(m32),
        .flag_invalid(fi32), .flag_overflow(fo32), .flag_underflow(fu32)
    );

    reflet_float_mult_seq #(.float_size(16)) dut16 (
        .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16),
        .in1(in1[15:0]), .in2(in2[15:0]), .out_valid(ov16), .out_ready(or16), .mult(m16),
        .flag_invalid(fi16), .flag_overflow(fo16), .flag_underflow(fu16)
    );

    // Reference: exact integer product, then round by comparing the dropped remainder to half an ulp.
    function automatic void model(input int fs, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r, output logic inv,
                                  output logic ovf, output logic unf);
        int     ew, mw, sh;
        longint one, bias, emax, sa, sb, s, ea, eb, ma, mb, p, q, rem, half, e;
        bit     nan_a, nan_b, inf_a, inf_b, z_a, z_b;
        one  = 1;
        ew   = (fs == 16) ? 5 : ((fs == 64) ? 11 : 8);
        mw   = fs - 1 - ew;
        bias = (one << (ew - 1)) - 1;
        emax = (one << ew) - 1;
        sa   = longint'(a >> (fs - 1)) & 1;
        sb   = longint'(b >> (fs - 1)) & 1;
        s    = sa ^ sb;
        ea   = longint'(a >> mw) & emax;
        eb   = longint'(b >> mw) & emax;
        ma   = longint'(a) & ((one << mw) - 1);
        mb   = longint'(b) & ((one << mw) - 1);
        nan_a = (ea == emax) && (ma != 0);
        nan_b = (eb == emax) && (mb != 0);
        inf_a = (ea == emax) && (ma == 0);
        inf_b = (eb == emax) && (mb == 0);
        z_a   = (ea == 0);
        z_b   = (eb == 0);
        inv = 1'b0;
        ovf = 1'b0;
        unf = 1'b0;
        if (nan_a || nan_b || (inf_a && z_b) || (inf_b && z_a)) begin
            r   = 64'((emax << mw) | (one << (mw - 1)));
            inv = 1'b1;
        end else if (inf_a || inf_b) begin
            r = 64'((s << (fs - 1)) | (emax << mw));
        end else if (z_a || z_b) begin
            r = 64'(s << (fs - 1));
        end else begin
            p = (ma | (one << mw)) * (mb | (one << mw));
            e = ea + eb - bias;
            if (p >= (one << (2 * mw + 1))) begin
                sh = mw + 1;
                e  = e + 1;
            end else begin
                sh = mw;
            end
            q    = p >> sh;
            rem  = p - (q << sh);
            half = one << (sh - 1);
            if (rem > half || (rem == half && (q & 1) == 1)) q = q + 1;
            if (q == (one << (mw + 1))) begin
                q = q >> 1;
                e = e + 1;
            end
            if (e >= emax) begin
                r   = 64'((s << (fs - 1)) | (emax << mw));
                ovf = 1'b1;
            end else if (e <= 0) begin
                r   = 64'(s << (fs - 1));
                unf = 1'b1;
            end else begin
                r = 64'((s << (fs - 1)) | (e << mw) | (q & ((one << mw) - 1)));
            end
        end
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic cur_ov(input int fs);
        return (fs == 32) ? ov32 : ov16;
    endfunction

    function automatic logic cur_ir(input int fs);
        return (fs == 32) ? ir32 : ir16;
    endfunction

    // Output checker: whenever a result is presented it must match the model.
    always @(negedge clk) begin
        if (reset && ov32) begin
            vectors++;
            if ({m32, fi32, fo32, fu32} !== {exp32, expf32}) begin
                miscompares++;
                $display("FAIL out32: got %h flags %b, expected %h flags %b",
                         m32, {fi32, fo32, fu32}, exp32, expf32);
            end
        end
        if (reset && ov16) begin
            vectors++;
            if ({m16, fi16, fo16, fu16} !== {exp16, expf16}) begin
                miscompares++;
                $display("FAIL out16: got %h flags %b, expected %h flags %b",
                         m16, {fi16, fo16, fu16}, exp16, expf16);
            end
        end
    end

    task automatic run_op(input int fs, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lit, input logic [2:0] lflags,
                          input int lat, input int hold);
        logic [63:0] r;
        logic        i, o, u;
        int          n;
        model(fs, {32'h0, a}, {32'h0, b}, r, i, o, u);
        check("model_literal", {29'h0, r[31:0], i, o, u}, {29'h0, lit, lflags});
        if (fs == 32) begin
            exp32  = r[31:0];
            expf32 = {i, o, u};
        end else begin
            exp16  = r[15:0];
            expf16 = {i, o, u};
        end
        @(negedge clk);
        in1  = a;
        in2  = b;
        or32 = (hold == 0);
        or16 = (hold == 0);
        if (fs == 32) iv32 = 1'b1;
        else iv16 = 1'b1;
        @(posedge clk);
        #1;
        iv32 = 1'b0;
        iv16 = 1'b0;
        in1  = $urandom;
        in2  = $urandom;
        check("in_ready_busy", 64'(cur_ir(fs)), 64'd0);
        n = 0;
        while (!cur_ov(fs) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", 64'(n), 64'(lat));
        if (hold == 0) begin
            @(posedge clk);
            #1;
            check("in_ready_after", 64'(cur_ir(fs)), 64'd1);
        end else begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1;
                check("bp_in_ready", 64'(cur_ir(fs)), 64'd0);
                if (h == 2) begin
                    in1 = 32'h3F80_3C00;
                    in2 = 32'h3F80_3C00;
                    if (fs == 32) iv32 = 1'b1;
                    else iv16 = 1'b1;
                end
                if (h == 3) begin
                    iv32 = 1'b0;
                    iv16 = 1'b0;
                end
            end
            check("bp_out_valid", 64'(cur_ov(fs)), 64'd1);
            or32 = 1'b1;
            or16 = 1'b1;
            @(posedge clk);
            #1;
            check("bp_release_ready", 64'(cur_ir(fs)), 64'd1);
            @(posedge clk);
            #1;
            check("bp_no_capture", 64'(cur_ov(fs)), 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before the bench completed");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        check("rst_in_ready32", 64'(ir32), 64'd1);
        check("rst_out_valid32", 64'(ov32), 64'd0);
        check("rst_mult32", 64'({m32, fi32, fo32, fu32}), 64'd0);
        check("rst_in_ready16", 64'(ir16), 64'd1);
        check("rst_mult16", 64'({ov16, m16, fi16, fo16, fu16}), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op(32, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 3'b000, 25, 0);
        run_op(32, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 3'b000, 25, 0);
        run_op(32, 32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 3'b000, 25, 0);
        run_op(32, 32'h8000_0000, 32'h4040_0000, 32'h8000_0000, 3'b000, 1, 0);
        run_op(32, 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 3'b000, 25, 0);
        run_op(32, 32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, 3'b000, 25, 0);
        run_op(32, 32'h3FC0_0001, 32'h3FC0_0001, 32'h4010_0002, 3'b000, 25, 0);
        run_op(32, 32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 3'b000, 25, 0);
        run_op(32, 32'h3F80_0003, 32'h3FC0_0000, 32'h3FC0_0004, 3'b000, 25, 0);
        run_op(32, 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b100, 1, 0);
        run_op(32, 32'hFFC1_2345, 32'h4000_0000, 32'h7FC0_0000, 3'b100, 1, 0);
        run_op(32, 32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 3'b000, 1, 0);
        run_op(32, 32'h0040_0000, 32'h4000_0000, 32'h0000_0000, 3'b000, 1, 0);
        run_op(32, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 3'b010, 25, 0);
        run_op(32, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 3'b001, 25, 0);
        run_op(32, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 3'b000, 25, 10);
        run_op(32, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 3'b010, 25, 10);

        // Reset in the middle of a multiplication.
        @(negedge clk);
        in1  = 32'h4000_0000;
        in2  = 32'h4040_0000;
        iv32 = 1'b1;
        @(posedge clk);
        #1;
        iv32 = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_out_valid", 64'(ov32), 64'd0);
        check("midrst_in_ready", 64'(ir32), 64'd1);
        check("midrst_mult", 64'({m32, fi32, fo32, fu32}), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_idle", 64'({ir32, ov32}), 64'b10);
        run_op(32, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 3'b000, 25, 0);

        run_op(16, 32'h0000_4000, 32'h0000_4200, 32'h0000_4600, 3'b000, 12, 0);
        run_op(16, 32'h0000_3E00, 32'h0000_3E00, 32'h0000_4080, 3'b000, 12, 0);
        run_op(16, 32'h0000_7800, 32'h0000_7800, 32'h0000_7C00, 3'b010, 12, 0);
        run_op(16, 32'h0000_7C00, 32'h0000_0000, 32'h0000_7E00, 3'b100, 1, 0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
